conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
// Sliding-window generator that consumes pixels from the read side of the async pixel FIFO.
// Sits in the read-clock domain directly downstream of the FIFO and ahead of the convolution datapath.
// Pops one raster-order pixel per cycle, keeps KERNEL-1 line buffers, and emits every full
// KERNEL x KERNEL window (valid region only, no padding) on a valid/ready stream.
// PARAMETERS
// DATA_WIDTH  8   pixel width in bits
// KERNEL      3   window edge length; must be >= 2 and <= IMG_WIDTH, IMG_HEIGHT
// IMG_WIDTH   8   pixels per image row
// IMG_HEIGHT  8   rows per frame
// PORTS
// clk           in   1                      read-side clock (same clock as the FIFO rd_clk)
// rst_n         in   1                      reset, asynchronous, active-low
// start         in   1                      one-cycle pulse; begins a frame when idle
// busy          out  1                      high from the cycle after an accepted start until frame_done
// frame_done    out  1                      one-cycle pulse after the last window handshake
// fifo_rd_en    out  1                      pop request to the FIFO
// fifo_rd_data  in   DATA_WIDTH             FIFO data; valid the cycle after fifo_rd_en && !fifo_empty
// fifo_empty    in   1                      FIFO empty flag
// win_valid     out  1                      window output valid
// win_ready     in   1                      downstream accept
// win_data      out  KERNEL*KERNEL*DATA_WIDTH  window; element (r,c) at [(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH]
// win_row       out  $clog2(IMG_HEIGHT)     image row of the window's top-left pixel
// win_col       out  $clog2(IMG_WIDTH)      image column of the window's top-left pixel
// BEHAVIOUR
// Reset: all outputs 0; FSM = IDLE; counters and skid cleared. Line-buffer RAM is not cleared.
// Reset mid-frame aborts immediately. No frame_done is issued. The next start begins a clean frame.
// FSM states and transitions:
//  IDLE: wait for start. start -> RUN, with pop counter, row and col cleared. start in any other state is ignored.
//  RUN:  pop until IMG_WIDTH*IMG_HEIGHT pops have been issued, then -> DRAIN.
//  DRAIN: wait until the last popped pixel is consumed, the skid is empty and the final window
//         is handshaken -> DONE.
//  DONE: frame_done=1 for one cycle -> IDLE.
// Pop rule: fifo_rd_en = RUN && !fifo_empty && pops_left>0 && !skid_valid && !(win_valid && !win_ready).
//  - Pop counter increments only when fifo_rd_en && !fifo_empty.
//  - At most one popped pixel is in flight. It arrives at t+1.
// Arriving pixel, at t+1:
//  - If the output register is free (!win_valid || win_ready), the pixel advances the window.
//  - Otherwise it goes into a 1-entry skid register.
//  - A skid pixel has priority over a new pop. No pixel is ever lost or duplicated.
// Window advance, per accepted pixel p at (row,col):
//  - Shift the window columns left.
//  - Load the new right column from line buffers [col] (rows oldest..newest) plus p.
//  - Write p into the line-buffer chain.
//  - col wraps at IMG_WIDTH-1, and row then increments.
// Output:
//  - win_valid is set the cycle after an advance where row>=KERNEL-1 && col>=KERNEL-1.
//  - win_row = row-KERNEL+1 and win_col = col-KERNEL+1.
//  - Latency: pop at t -> window visible at t+2.
//  - win_data/win_row/win_col are held stable while win_valid && !win_ready.
//  - win_valid clears on handshake unless a new window loads in the same cycle.
//  - Windows spanning a row wrap (col<KERNEL-1) are never emitted. Row-0 columns from a previous frame never appear.
// Throughput: one window per cycle with continuous FIFO data and win_ready=1.
//  Windows per frame: (IMG_WIDTH-KERNEL+1)*(IMG_HEIGHT-KERNEL+1).
// TESTING
// 1. 8x8 ramp 0..63 via FIFO, win_ready=1:
//    - first window at (0,0) = {0,1,2, 8,9,10, 16,17,18};
//    - 36 windows total, last at (5,5) = {45,46,47, 53,54,55, 61,62,63};
//    - frame_done pulses once, 1 cycle after the last handshake.
// 2. Same frame, win_ready random 50%:
//    - identical 36-window sequence;
//    - fifo_rd_en never high while the skid is valid or the output is stalled.
// 3. FIFO empty bubbles every third cycle: window sequence unchanged, fifo_rd_en=0 whenever fifo_empty=1.
// 4. Two back-to-back frames, second = 100..163:
//    - second frame's first window = {100,101,102, 108,109,110, 116,117,118};
//    - no frame-1 data leaks.
// 5. rst_n low mid-frame after 20 pops:
//    - outputs 0 immediately, state IDLE;
//    - a new start + ramp gives the case-1 result.
// 6. start pulsed while busy: ignored, pop count still exactly 64, one frame_done only.

Source files
------------

// File: rtl/conv_window_gen.sv
// Sliding KERNEL x KERNEL window generator fed from the read side of the async pixel FIFO.
// Keeps KERNEL-1 line buffers and streams every valid-region window on a valid/ready port.
module conv_window_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KERNEL     = 3,
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]                  fifo_rd_data,
  input  logic                                   fifo_empty,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]    win_data,
  output logic [$clog2(IMG_HEIGHT)-1:0]          win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]           win_col
);

  localparam int unsigned TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      pop_cnt;
  logic                  in_flight;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;

  logic                  out_free_c;
  logic                  pop_c;
  logic                  advance_c;
  logic                  emit_c;
  logic                  start_c;
  logic [DATA_WIDTH-1:0] pix_c;

  logic [DATA_WIDTH-1:0] lb      [KERNEL-1][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win     [KERNEL][KERNEL];
  logic [DATA_WIDTH-1:0] new_col_c [KERNEL];

  // Skid and in-flight pixel are mutually exclusive: a pop is never issued while either could collide.
  assign out_free_c = !win_valid || win_ready;
  assign fifo_rd_en = (state == ST_RUN) && !fifo_empty && (pop_cnt < CNT_W'(TOTAL)) &&
                      !skid_valid && out_free_c;
  assign pop_c      = fifo_rd_en && !fifo_empty;
  assign pix_c      = skid_valid ? skid_data : fifo_rd_data;
  assign advance_c  = (skid_valid || in_flight) && out_free_c;
  assign emit_c     = advance_c && (row >= ROW_W'(KERNEL - 1)) && (col >= COL_W'(KERNEL - 1));
  assign start_c    = (state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (pop_cnt == CNT_W'(TOTAL)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!in_flight && !skid_valid && out_free_c) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Right-hand column entering the window: line buffers oldest..newest, then the live pixel.
  always_comb begin
    for (int r = 0; r < KERNEL; r++) new_col_c[r] = pix_c;
    for (int r = 0; r < KERNEL - 1; r++) new_col_c[r] = lb[r][col];
  end

  always_comb begin
    win_data = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        win_data[(r*KERNEL + c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pop_cnt    <= '0;
      in_flight  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      row        <= '0;
      col        <= '0;
    end else begin
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= (state_nxt == ST_DONE);
      in_flight  <= pop_c;
      if (start_c)    pop_cnt <= '0;
      else if (pop_c) pop_cnt <= pop_cnt + CNT_W'(1);
      if (in_flight && !out_free_c) begin
        skid_valid <= 1'b1;
        skid_data  <= fifo_rd_data;
      end else if (skid_valid && out_free_c) begin
        skid_valid <= 1'b0;
      end
      if (start_c) begin
        row <= '0;
        col <= '0;
      end else if (advance_c) begin
        if (col == COL_W'(IMG_WIDTH - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Line buffers are plain storage; per column they form a KERNEL-1 deep shift chain.
  always_ff @(posedge clk) begin
    if (advance_c) begin
      for (int k = 0; k < KERNEL - 2; k++) lb[k][col] <= lb[k+1][col];
      lb[KERNEL-2][col] <= pix_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) win[r][c] <= '0;
      end
    end else if (advance_c) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) win[r][c] <= win[r][c+1];
        win[r][KERNEL-1] <= new_col_c[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (emit_c) begin
      win_valid <= 1'b1;
      win_row   <= row - ROW_W'(KERNEL - 1);
      win_col   <= col - COL_W'(KERNEL - 1);
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a FIFO model feeds frames, expected windows are
// queued when a frame is loaded and popped on every output handshake.
module tb_conv_window_gen;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NWIN = (W - K + 1) * (H - K + 1);
  localparam int WD   = K * K * DW;

  typedef struct {
    logic [WD-1:0] data;
    int            row;
    int            col;
  } win_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          win_valid;
  logic          win_ready;
  logic [WD-1:0] win_data;
  logic [2:0]    win_row;
  logic [2:0]    win_col;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] pix_q[$];
  win_t          exp_q[$];
  win_t          mon_e;

  int  pops = 0;
  int  cyc = 0;
  int  ncyc = 0;
  int  done_cnt = 0;
  int  win_cnt = 0;
  int  fw = 0;
  int  last_hs = -10;
  bit  ready_rand = 0;
  bit  bubble_en = 0;
  bit  held = 0;
  logic [WD-1:0] held_data;
  logic [2:0]    held_row;
  logic [2:0]    held_col;

  conv_window_gen #(
    .DATA_WIDTH(DW), .KERNEL(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a successful pop; flags/ready change just after the edge.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty && pix_q.size() > 0) begin
      fifo_rd_data <= pix_q.pop_front();
      pops++;
    end
    #1;
    cyc++;
    fifo_empty = (pix_q.size() == 0) || (bubble_en && (cyc % 3 == 0));
    win_ready  = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      ncyc++;
      if (win_valid && !win_ready) begin
        checks++;
        if (fifo_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL pop_while_stalled: fifo_rd_en=%b required 0 (cycle %0d)", fifo_rd_en, ncyc);
        end
      end
      if (fifo_empty) begin
        checks++;
        if (fifo_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL pop_while_empty: fifo_rd_en=%b required 0 (cycle %0d)", fifo_rd_en, ncyc);
        end
      end
      if (held) begin
        checks++;
        if (win_valid !== 1'b1 || win_data !== held_data || win_row !== held_row || win_col !== held_col) begin
          errors++;
          $display("FAIL hold_stable: valid=%b data=%h (%0d,%0d) required 1 %h (%0d,%0d)",
                   win_valid, win_data, win_row, win_col, held_data, held_row, held_col);
        end
      end
      if (win_valid && win_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got %h at (%0d,%0d) required none", win_data, win_row, win_col);
        end else begin
          mon_e = exp_q.pop_front();
          if (win_data !== mon_e.data || win_row !== 3'(mon_e.row) || win_col !== 3'(mon_e.col)) begin
            errors++;
            $display("FAIL window: got %h at (%0d,%0d) required %h at (%0d,%0d)",
                     win_data, win_row, win_col, mon_e.data, mon_e.row, mon_e.col);
          end
        end
        win_cnt++;
        fw++;
        if (fw == NWIN) last_hs = ncyc;
      end
      if (frame_done) begin
        checks++;
        done_cnt++;
        if (ncyc != last_hs + 1 || fw != NWIN) begin
          errors++;
          $display("FAIL frame_done_timing: at cycle %0d after %0d windows, required cycle %0d after %0d",
                   ncyc, fw, last_hs + 1, NWIN);
        end
        fw = 0;
      end
      held      = win_valid && !win_ready;
      held_data = win_data;
      held_row  = win_row;
      held_col  = win_col;
    end
  end

  task automatic load_frame(input int base);
    win_t e;
    for (int i = 0; i < W * H; i++) pix_q.push_back(8'(base + i));
    for (int wr = 0; wr <= H - K; wr++) begin
      for (int wc = 0; wc <= W - K; wc++) begin
        e.row = wr;
        e.col = wc;
        e.data = '0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            e.data[(i*K + j)*DW +: DW] = 8'(base + (wr + i) * W + wc + j);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: busy=%b required 1", busy);
    end
  endtask

  task automatic wait_done(input int target, output int cycles);
    cycles = 0;
    while (done_cnt < target && cycles < 5000) begin
      @(negedge clk);
      #2;
      cycles++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, frame_done, fifo_rd_en, win_valid} !== 4'b0 || win_data !== '0 ||
        win_row !== 3'd0 || win_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b valid=%b data=%h row=%0d col=%0d required all 0",
               busy, frame_done, fifo_rd_en, win_valid, win_data, win_row, win_col);
    end
  endtask

  task automatic test_ramp();
    int d0, w0, cycles;
    d0 = done_cnt; w0 = win_cnt; pops = 0;
    load_frame(0);
    pulse_start();
    wait_done(d0 + 1, cycles);
    checks++;
    if (done_cnt < d0 + 1 || cycles > 72) begin
      errors++;
      $display("FAIL ramp_throughput: done after %0d cycles (count %0d) required <=72", cycles, done_cnt - d0);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (win_cnt - w0 != NWIN || pops != W * H || done_cnt != d0 + 1 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ramp_totals: wins=%0d pops=%0d dones=%0d left=%0d busy=%b required %0d %0d 1 0 0",
               win_cnt - w0, pops, done_cnt - d0, exp_q.size(), busy, NWIN, W * H);
    end
  endtask

  task automatic test_random_ready();
    int d0, w0, cycles;
    d0 = done_cnt; w0 = win_cnt; pops = 0;
    ready_rand = 1'b1;
    load_frame(0);
    pulse_start();
    wait_done(d0 + 1, cycles);
    ready_rand = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (win_cnt - w0 != NWIN || pops != W * H || done_cnt != d0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_ready_totals: wins=%0d pops=%0d dones=%0d left=%0d required %0d %0d 1 0",
               win_cnt - w0, pops, done_cnt - d0, exp_q.size(), NWIN, W * H);
    end
  endtask

  task automatic test_bubbles();
    int d0, w0, cycles;
    d0 = done_cnt; w0 = win_cnt; pops = 0;
    bubble_en = 1'b1;
    ready_rand = 1'b1;
    load_frame(0);
    pulse_start();
    wait_done(d0 + 1, cycles);
    bubble_en = 1'b0;
    ready_rand = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (win_cnt - w0 != NWIN || pops != W * H || done_cnt != d0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bubble_totals: wins=%0d pops=%0d dones=%0d left=%0d required %0d %0d 1 0",
               win_cnt - w0, pops, done_cnt - d0, exp_q.size(), NWIN, W * H);
    end
  endtask

  task automatic test_back_to_back();
    int d0, w0, cycles;
    d0 = done_cnt; w0 = win_cnt; pops = 0;
    load_frame(0);
    load_frame(100);
    pulse_start();
    wait_done(d0 + 1, cycles);
    checks++;
    if (pops != W * H || done_cnt != d0 + 1 || win_cnt - w0 != NWIN) begin
      errors++;
      $display("FAIL b2b_first_frame: pops=%0d dones=%0d wins=%0d required %0d 1 %0d",
               pops, done_cnt - d0, win_cnt - w0, W * H, NWIN);
    end
    pulse_start();
    wait_done(d0 + 2, cycles);
    repeat (10) @(negedge clk);
    checks++;
    if (pops != 2 * W * H || done_cnt != d0 + 2 || win_cnt - w0 != 2 * NWIN || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_second_frame: pops=%0d dones=%0d wins=%0d left=%0d required %0d 2 %0d 0",
               pops, done_cnt - d0, win_cnt - w0, exp_q.size(), 2 * W * H, 2 * NWIN);
    end
  endtask

  task automatic test_reset_mid();
    int d0, w0, cycles, guard;
    d0 = done_cnt; pops = 0;
    ready_rand = 1'b1;
    load_frame(0);
    pulse_start();
    guard = 0;
    while (pops < 20 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (pops < 20) begin
      errors++;
      $display("FAIL reset_mid_progress: pops=%0d required 20", pops);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, fifo_rd_en, win_valid} !== 4'b0 || win_data !== '0 ||
        win_row !== 3'd0 || win_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b rd_en=%b valid=%b data=%h required all 0",
               busy, frame_done, fifo_rd_en, win_valid, win_data);
    end
    pix_q.delete();
    exp_q.delete();
    held = 0;
    fw = 0;
    ready_rand = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: dones=%0d busy=%b required 0 0", done_cnt - d0, busy);
    end
    w0 = win_cnt; pops = 0;
    load_frame(0);
    pulse_start();
    wait_done(d0 + 1, cycles);
    repeat (10) @(negedge clk);
    checks++;
    if (win_cnt - w0 != NWIN || pops != W * H || done_cnt != d0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_rerun: wins=%0d pops=%0d dones=%0d left=%0d required %0d %0d 1 0",
               win_cnt - w0, pops, done_cnt - d0, exp_q.size(), NWIN, W * H);
    end
  endtask

  task automatic test_start_while_busy();
    int d0, w0, cycles;
    d0 = done_cnt; w0 = win_cnt; pops = 0;
    load_frame(0);
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0 + 1, cycles);
    repeat (20) @(negedge clk);
    checks++;
    if (pops != W * H || done_cnt != d0 + 1 || win_cnt - w0 != NWIN || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_while_busy: pops=%0d dones=%0d wins=%0d busy=%b left=%0d required %0d 1 %0d 0 0",
               pops, done_cnt - d0, win_cnt - w0, busy, exp_q.size(), W * H, NWIN);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    win_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    held_data = '0;
    held_row = '0;
    held_col = '0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_ramp();
    test_random_ready();
    test_bubbles();
    test_back_to_back();
    test_reset_mid();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
